// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with optional fall-through and fill-level flags.
// Pointers wrap at DEPTH-1, so any DEPTH >= 1 is supported.
module sync_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned THRESHOLD    = 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic testmode_i,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    output logic threshold_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
    localparam cnt_t THR_CNT  = cnt_t'(THRESHOLD);

    dtype mem_q [DEPTH];
    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    cnt_t cnt_q, cnt_d;

    logic is_empty;
    logic bypass;
    logic consume;
    logic push_eff;
    logic pop_eff;
    logic we;

    // Test mode carries no function in this block.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // Status flags, head data and the effective push/pop qualifiers.
    always_comb begin
        is_empty    = (cnt_q == '0);
        bypass      = FALL_THROUGH && is_empty && push_i;
        full_o      = (cnt_q == FULL_CNT);
        threshold_o = (cnt_q >= THR_CNT);
        empty_o     = is_empty && !bypass;
        data_o      = bypass ? data_i : mem_q[rptr_q];
        push_eff    = push_i && !full_o;
        pop_eff     = pop_i && !empty_o;
        consume     = bypass && pop_i;
    end

    // Next-state for pointers and fill count; flush wins over push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        we     = 1'b0;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else if (!consume) begin
            if (push_eff) begin
                we     = 1'b1;
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop_eff) begin
                rptr_d = ptr_inc(rptr_q);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   cnt_d = cnt_t'(cnt_q + 1'b1);
                2'b01:   cnt_d = cnt_t'(cnt_q - 1'b1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage; flush leaves stale entries in place.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: four FIFO configurations driven by one stimulus stream,
// each compared against its own queue-based reference.
module tb_sync_fifo;

    localparam int    N      = 4;
    localparam int    DEP[N] = '{4, 3, 4, 1};
    localparam int    THR[N] = '{2, 3, 2, 1};
    localparam bit    FT[N]  = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tm;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;

    logic       full  [N];
    logic       empty [N];
    logic       thr   [N];
    logic [7:0] dout  [N];

    typedef logic [7:0] q_t[$];
    q_t mq [N];

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    sync_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4), .THRESHOLD(2)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm), .flush_i(flush),
        .full_o(full[0]), .empty_o(empty[0]), .threshold_o(thr[0]),
        .data_i(din), .push_i(push), .data_o(dout[0]), .pop_i(pop)
    );

    sync_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3), .THRESHOLD(3)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm), .flush_i(flush),
        .full_o(full[1]), .empty_o(empty[1]), .threshold_o(thr[1]),
        .data_i(din), .push_i(push), .data_o(dout[1]), .pop_i(pop)
    );

    sync_fifo #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4), .THRESHOLD(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm), .flush_i(flush),
        .full_o(full[2]), .empty_o(empty[2]), .threshold_o(thr[2]),
        .data_i(din), .push_i(push), .data_o(dout[2]), .pop_i(pop)
    );

    sync_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(1), .THRESHOLD(1)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(tm), .flush_i(flush),
        .full_o(full[3]), .empty_o(empty[3]), .threshold_o(thr[3]),
        .data_i(din), .push_i(push), .data_o(dout[3]), .pop_i(pop)
    );

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s u%0d: observed %0h expected %0h", tag, k, obs, exp);
    endtask

    // One cycle: drive inputs after the falling edge, compare, advance models.
    task automatic step(input logic pu, input logic po,
                        input logic fl, input logic [7:0] d);
        @(negedge clk);
        push  = pu;
        pop   = po;
        flush = fl;
        din   = d;
        tm    = 1'($urandom);
        #1;
        for (int k = 0; k < N; k++) begin
            int n;
            bit byp;
            n   = mq[k].size();
            byp = FT[k] && (n == 0) && pu;
            chk("full",  k, 32'(full[k]),  32'(n == DEP[k]));
            chk("thr",   k, 32'(thr[k]),   32'(n >= THR[k]));
            chk("empty", k, 32'(empty[k]), 32'((n == 0) && !byp));
            if (byp)
                chk("data_bypass", k, 32'(dout[k]), 32'(d));
            else if (n > 0)
                chk("data_head", k, 32'(dout[k]), 32'(mq[k][0]));
            if (fl) begin
                mq[k].delete();
            end else if (!(byp && po)) begin
                if (po && n > 0) void'(mq[k].pop_front());
                if (pu && n < DEP[k]) mq[k].push_back(d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tm    = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rst_empty", k, 32'(empty[k]), 32'd1);
            chk("rst_full",  k, 32'(full[k]),  32'd0);
            chk("rst_thr",   k, 32'(thr[k]),   32'd0);
            chk("rst_data",  k, 32'(dout[k]),  32'd0);
        end

        step(1, 0, 0, 8'hA);
        step(1, 0, 0, 8'hB);
        step(1, 0, 0, 8'hC);
        step(1, 0, 0, 8'hD);
        step(0, 0, 0, 8'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h0);

        step(1, 0, 0, 8'h20);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 8'h30 + 8'(i));
        step(0, 0, 1, 8'h0);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h40 + 8'(i));
        step(1, 1, 0, 8'hE);
        step(0, 0, 0, 8'h0);
        step(0, 0, 1, 8'h0);

        step(1, 0, 0, 8'h51);
        step(1, 0, 0, 8'h52);
        step(1, 0, 1, 8'h53);
        step(0, 0, 0, 8'h0);

        step(1, 1, 0, 8'h5);
        step(0, 0, 0, 8'h0);
        step(0, 1, 0, 8'h0);
        step(1, 0, 0, 8'h61);
        step(1, 0, 0, 8'h62);
        step(0, 0, 0, 8'h0);
        step(0, 0, 1, 8'h0);

        for (int i = 0; i < 600; i++) begin
            logic pu, po, fl;
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            step(pu, po, fl, 8'($urandom));
        end
        step(0, 0, 0, 8'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
